// File: rtl/sys_clk_rst_ctrl.sv
// Root clock/reset housekeeping: synchronised and stretched system reset,
// standby handshake, and free-running 1 us / 1 ms timebase strobes.
module sys_clk_rst_ctrl #(
   parameter int CLK_FREQ_HZ = 38_000_000,
   parameter int PUR_CYCLES  = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TICK_DIV    = CLK_FREQ_HZ / 1_000_000
) (
   input  logic       sys_clk,
   input  logic       resetn,
   input  logic       stdby,
   output logic       sys_resetn,
   output logic       clk_en,
   output logic       stdby_ack,
   output logic       us_tick,
   output logic       ms_tick,
   output logic [3:0] dbg
);

   typedef enum logic [1:0] {
      ST_RESET   = 2'd0,
      ST_STRETCH = 2'd1,
      ST_RUN     = 2'd2,
      ST_STANDBY = 2'd3
   } state_t;

   localparam int SW = (PUR_CYCLES > 1) ? $clog2(PUR_CYCLES) : 1;
   localparam int UW = $clog2(TICK_DIV);
   localparam logic [SW-1:0] STRETCH_LAST = SW'(PUR_CYCLES - 1);
   localparam logic [UW-1:0] US_LAST      = UW'(TICK_DIV - 1);
   localparam logic [9:0]    MS_LAST      = 10'd999;

   state_t                 state, state_nx;
   logic [SYNC_STAGES-1:0] rst_sync;
   logic [SYNC_STAGES-1:0] stdby_sync;
   logic [SW-1:0]          stretch_cnt;
   logic [UW-1:0]          us_cnt;
   logic [9:0]             ms_cnt;
   logic                   rst_rel;
   logic                   stdby_req;
   logic                   us_wrap;

   // Decisions are taken on the edge the final synchroniser stage loads its 1,
   // so they look at that stage's input; this gives a SYNC_STAGES-edge latency.
   assign rst_rel   = rst_sync[SYNC_STAGES-2];
   assign stdby_req = stdby_sync[SYNC_STAGES-2];
   assign dbg       = {rst_sync[SYNC_STAGES-1], stdby_sync[SYNC_STAGES-1], state};

   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         rst_sync   <= '0;
         stdby_sync <= '0;
      end else begin
         rst_sync   <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
         stdby_sync <= {stdby_sync[SYNC_STAGES-2:0], stdby};
      end
   end

   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) state <= ST_RESET;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      us_wrap  = 1'b0;
      unique case (state)
         ST_RESET:   if (rst_rel) state_nx = ST_STRETCH;
         ST_STRETCH: if (stretch_cnt == STRETCH_LAST) state_nx = ST_RUN;
         ST_RUN: begin
            us_wrap = (us_cnt == US_LAST);
            if (stdby_req) state_nx = ST_STANDBY;
         end
         ST_STANDBY: if (!stdby_req) state_nx = ST_RUN;
         default:    state_nx = ST_RESET;
      endcase
   end

   // Counters only advance in RUN; STANDBY freezes them in place.
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         stretch_cnt <= '0;
         us_cnt      <= '0;
         ms_cnt      <= '0;
      end else begin
         stretch_cnt <= (state == ST_STRETCH) ? stretch_cnt + 1'b1 : '0;
         if (state == ST_RUN) us_cnt <= us_wrap ? '0 : us_cnt + 1'b1;
         if (us_wrap) ms_cnt <= (ms_cnt == MS_LAST) ? 10'd0 : ms_cnt + 10'd1;
      end
   end

   // A tick due on the edge standby is taken still fires.
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         sys_resetn <= 1'b0;
         clk_en     <= 1'b0;
         stdby_ack  <= 1'b0;
         us_tick    <= 1'b0;
         ms_tick    <= 1'b0;
      end else begin
         sys_resetn <= (state_nx == ST_RUN) || (state_nx == ST_STANDBY);
         clk_en     <= (state_nx == ST_RUN);
         stdby_ack  <= (state_nx == ST_STANDBY);
         us_tick    <= us_wrap;
         ms_tick    <= us_wrap && (ms_cnt == MS_LAST);
      end
   end

endmodule

// File: tb/tb_sys_clk_rst_ctrl.sv
// Directed bench for sys_clk_rst_ctrl with default parameters (TICK_DIV=38).
module tb_sys_clk_rst_ctrl;

   logic       sys_clk;
   logic       resetn;
   logic       stdby;
   logic       sys_resetn;
   logic       clk_en;
   logic       stdby_ack;
   logic       us_tick;
   logic       ms_tick;
   logic [3:0] dbg;

   int n_cmp = 0;
   int n_err = 0;

   sys_clk_rst_ctrl dut (
      .sys_clk    (sys_clk),
      .resetn     (resetn),
      .stdby      (stdby),
      .sys_resetn (sys_resetn),
      .clk_en     (clk_en),
      .stdby_ack  (stdby_ack),
      .us_tick    (us_tick),
      .ms_tick    (ms_tick),
      .dbg        (dbg)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   // Expects resetn to have just risen at a negedge.
   task automatic release_seq(input string tag);
      repeat (2) step();
      check({tag, "_stretch_state"}, 32'(dbg[1:0]), 32'd1);
      repeat (15) step();
      check({tag, "_e17_sys_resetn"}, 32'(sys_resetn), 32'd0);
      check({tag, "_e17_clk_en"}, 32'(clk_en), 32'd0);
      step();
      check({tag, "_e18_sys_resetn"}, 32'(sys_resetn), 32'd1);
      check({tag, "_e18_clk_en"}, 32'(clk_en), 32'd1);
      check({tag, "_e18_state"}, 32'(dbg[1:0]), 32'd2);
   endtask

   initial begin
      logic flag;
      logic ms_bad;
      int   ticks;
      int   cyc;

      resetn = 1'b0;
      stdby  = 1'b0;
      #20;
      check("rst_sys_resetn", 32'(sys_resetn), 32'd0);
      check("rst_clk_en", 32'(clk_en), 32'd0);
      check("rst_stdby_ack", 32'(stdby_ack), 32'd0);
      check("rst_ticks", 32'({us_tick, ms_tick}), 32'd0);
      check("rst_dbg", 32'(dbg), 32'd0);

      // Power-up
      @(negedge sys_clk);
      resetn = 1'b1;
      release_seq("pwr");

      // us_tick cadence from RUN entry
      flag = 1'b0;
      repeat (37) begin
         step();
         if (us_tick) flag = 1'b1;
      end
      check("us_no_early", 32'(flag), 32'd0);
      step();
      check("us_first", 32'(us_tick), 32'd1);
      check("ms_not_first", 32'(ms_tick), 32'd0);
      step();
      check("us_width", 32'(us_tick), 32'd0);
      repeat (37) step();
      check("us_period", 32'(us_tick), 32'd1);

      // ms_tick on the 1000th us_tick, 38000 cycles after RUN entry
      ticks  = 2;
      cyc    = 76;
      ms_bad = 1'b0;
      while (ticks < 1000 && cyc < 40000) begin
         step();
         cyc++;
         if (us_tick) ticks++;
         if (ms_tick && (!us_tick || ticks != 1000)) ms_bad = 1'b1;
      end
      check("ms_cycle", 32'(cyc), 32'd38000);
      check("ms_coincide", 32'({ms_tick, us_tick}), 32'd3);
      check("ms_no_early", 32'(ms_bad), 32'd0);
      step();
      check("ms_width", 32'(ms_tick), 32'd0);

      // Standby after 10 RUN cycles into a us period
      repeat (9) step();
      stdby = 1'b1;
      step();
      check("sb_e1_ack", 32'(stdby_ack), 32'd0);
      check("sb_e1_clk_en", 32'(clk_en), 32'd1);
      step();
      check("sb_e2_ack", 32'(stdby_ack), 32'd1);
      check("sb_e2_clk_en", 32'(clk_en), 32'd0);
      check("sb_sys_resetn", 32'(sys_resetn), 32'd1);
      flag = 1'b0;
      repeat (50) begin
         step();
         if (us_tick || ms_tick || clk_en) flag = 1'b1;
      end
      check("sb_quiet", 32'(flag), 32'd0);
      stdby = 1'b0;
      step();
      check("sb_exit_e1", 32'(clk_en), 32'd0);
      step();
      check("sb_exit_e2_clk_en", 32'(clk_en), 32'd1);
      check("sb_exit_e2_ack", 32'(stdby_ack), 32'd0);
      // 12 RUN cycles were spent before the pause; 26 remain
      flag = 1'b0;
      repeat (25) begin
         step();
         if (us_tick) flag = 1'b1;
      end
      check("sb_resume_no_early", 32'(flag), 32'd0);
      step();
      check("sb_resume_tick", 32'(us_tick), 32'd1);

      // Async reset between edges while us_tick is high
      #2 resetn = 1'b0;
      #1;
      check("async_sys_resetn", 32'(sys_resetn), 32'd0);
      check("async_clk_en", 32'(clk_en), 32'd0);
      check("async_us_tick", 32'(us_tick), 32'd0);
      @(negedge sys_clk);
      resetn = 1'b1;
      release_seq("rerun");

      // stdby held through reset release
      #2 resetn = 1'b0;
      stdby = 1'b1;
      #10;
      @(negedge sys_clk);
      resetn = 1'b1;
      repeat (17) step();
      check("sbr_e17_sys_resetn", 32'(sys_resetn), 32'd0);
      step();
      check("sbr_e18_run", 32'({sys_resetn, clk_en, stdby_ack}), 32'b110);
      step();
      check("sbr_e19_standby", 32'({sys_resetn, clk_en, stdby_ack}), 32'b101);
      stdby = 1'b0;
      repeat (2) step();
      check("sbr_back_run", 32'({sys_resetn, clk_en, stdby_ack}), 32'b110);

      // Reset glitch ten cycles into STRETCH
      #2 resetn = 1'b0;
      #5;
      @(negedge sys_clk);
      resetn = 1'b1;
      repeat (10) step();
      check("glitch_in_stretch", 32'(dbg[1:0]), 32'd1);
      #2 resetn = 1'b0;
      #1;
      check("glitch_state", 32'(dbg[1:0]), 32'd0);
      check("glitch_sys_resetn", 32'(sys_resetn), 32'd0);
      @(negedge sys_clk);
      resetn = 1'b1;
      release_seq("glitch");

      // Reset while in STANDBY drops stdby_ack at once
      stdby = 1'b1;
      repeat (2) step();
      check("sbrst_ack_pre", 32'(stdby_ack), 32'd1);
      #2 resetn = 1'b0;
      #1;
      check("sbrst_ack_post", 32'(stdby_ack), 32'd0);
      check("sbrst_sys_resetn", 32'(sys_resetn), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
